uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver that consumes the 16x oversampling strobe (tick_16) from the baud generator and deserialises the asynchronous serial line into parallel bytes. Frame format is 1 start bit, DATA_BITS data bits LSB first, an optional parity bit, and 1 stop bit. Received words are held in an output register with a valid/ready handshake toward the downstream consumer (FIFO or host logic).

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5–8.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
tick_16  input  1  one-clk strobe at 16x baud rate, from baud generator
rx  input  1  asynchronous serial line; idles high
rx_ready  input  1  consumer accepts rx_data this cycle
rx_data  output  DATA_BITS  received word, right-aligned
rx_valid  output  1  rx_data holds an unconsumed word
frame_err  output  1  stop bit sampled 0; qualifies rx_data while rx_valid
parity_err  output  1  parity mismatch; qualifies rx_data while rx_valid; always 0 when PARITY_EN = 0
overrun_err  output  1  one-clk pulse: a frame was dropped because rx_valid was still high
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous, active-high, and has priority over all other activity.
- Reset values: rx_data = 0, rx_valid = 0, frame_err = 0, parity_err = 0, overrun_err = 0, busy = 0. Synchroniser flops reset to 1. State = IDLE. Sample counter, bit counter and shift register reset to 0.
- rx passes through a 2-flop synchroniser to give rx_s; all decisions use rx_s.
- The 4-bit sample counter (scnt) and all state transitions advance only on cycles where tick_16 = 1. The output handshake logic runs every clk.
- IDLE: on a tick with rx_s = 0, go to START with scnt = 0.
- START: on each tick, scnt increments. At the tick where scnt = 7 (mid start bit):
  - rx_s = 0: go to DATA with scnt = 0 and bitcnt = 0.
  - rx_s = 1: false start; return to IDLE with no outputs changed.
- DATA: on the tick where scnt = 15, sample rx_s into bit position bitcnt (LSB first), set scnt = 0, and increment bitcnt. After bit DATA_BITS-1 is sampled, go to PARITY if PARITY_EN = 1, otherwise to STOP.
- PARITY: on the tick where scnt = 15, compute perr = (XOR of the data bits ^ rx_s ^ PARITY_ODD). Go to STOP.
- STOP: on the tick where scnt = 15, compute ferr = ~rx_s. Deliver the frame and go to IDLE.
  - If the line is still low (break), IDLE restarts immediately. Such frames deliver 0x00 with frame_err = 1; this is the required behaviour.
- Deliver, registered; takes effect the clk after the stop-bit sample tick:
  - If rx_valid = 0, or rx_valid = 1 and rx_ready = 1 in the same cycle: load rx_data, frame_err = ferr, parity_err = perr, and rx_valid = 1.
  - Otherwise (rx_valid = 1 and rx_ready = 0): drop the new frame, keep the old word and flags, and pulse overrun_err high for 1 clk.
- Handshake: rx_valid clears the cycle after a clk with rx_valid = 1 and rx_ready = 1, unless a delivery occurs on that same clk. rx_ready while rx_valid = 0 is ignored. rx_data and the error flags are stable while rx_valid = 1 and do not change on consumption.
- tick_16 arriving while mid-frame is never skipped. Latency from the line entering the stop bit to rx_valid rising is 8 ticks plus 3 clk (2 synchroniser clk + 1 output register clk), ±1 tick of start-edge detection jitter.
- A reset asserted mid-frame aborts it. No delivery occurs, and reception resumes from IDLE on the next falling edge.

Test Plan:
- Bench drives tick_16 every 4 clk (1 bit = 64 clk). Send 0xA5, 8N1. Expect: rx_data = 0xA5, rx_valid = 1, frame_err = 0, parity_err = 0, busy = 0 after stop. Assert rx_ready for 1 clk; rx_valid drops the next clk.
- Drive rx low for 4 ticks, then high. Expect: state returns to IDLE, busy pulses then falls, rx_valid stays 0, no error flags.
- PARITY_EN = 1, PARITY_ODD = 0, send 0x37 (five ones) with parity bit 1. Expect parity_err = 0. Resend with parity bit 0. Expect rx_data = 0x37 and parity_err = 1.
- Send 0x3C with the stop bit held 0. Expect rx_data = 0x3C, frame_err = 1, rx_valid = 1.
- Send 0x11 and leave rx_ready = 0, then send 0x22. Expect: overrun_err pulses 1 clk, rx_data stays 0x11. Repeat with rx_ready = 1 on the exact delivery clk of 0x22: expect rx_data = 0x22, rx_valid held 1, no overrun.
- Assert reset during data bit 3 of 0xFF, then send 0x5A after release. Expect no delivery from the aborted frame; rx_data = 0x5A delivered correctly.

Source files
------------

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// UART receiver driven by a 16x oversampling strobe. Deserialises frames of
// 1 start bit, DATA_BITS data bits (LSB first), an optional parity bit and
// 1 stop bit. Received words are held in an output register with a
// valid/ready handshake toward the downstream consumer.
//
// Parameters:
//   DATA_BITS   data bits per frame (5..8)
//   PARITY_EN   1 = a parity bit follows the data bits
//   PARITY_ODD  0 = even parity, 1 = odd parity (ignored if PARITY_EN = 0)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   tick_16      one-clk strobe at 16x the baud rate
//   rx           asynchronous serial line, idles high
//   rx_ready     consumer accepts rx_data this cycle
//   rx_data      received word, right-aligned
//   rx_valid     rx_data holds an unconsumed word
//   frame_err    stop bit sampled low (qualifies rx_data)
//   parity_err   parity mismatch (qualifies rx_data)
//   overrun_err  one-clk pulse when a frame is dropped because rx_valid was high
//   busy         receiver is somewhere inside a frame
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick_16,
    input  logic                 rx,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
    localparam logic       PAR_EN_BIT  = (PARITY_EN != 0);
    localparam logic       PAR_ODD_BIT = (PARITY_ODD != 0);

    state_t               state, state_nxt;
    logic [3:0]           scnt, scnt_nxt;
    logic [2:0]           bitcnt, bitcnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 perr_q, perr_nxt;
    logic                 deliver;
    logic                 ferr_now;
    logic                 rx_meta;
    logic                 rx_s;

    // Two-flop synchroniser; resets to the idle (high) line level so a reset
    // never looks like a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            scnt   <= 4'd0;
            bitcnt <= 3'd0;
            shreg  <= '0;
            perr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            scnt   <= scnt_nxt;
            bitcnt <= bitcnt_nxt;
            shreg  <= shreg_nxt;
            perr_q <= perr_nxt;
        end
    end

    // Frame sequencing. Everything advances only on tick_16. Data bits enter
    // at the MSB and shift right, so after DATA_BITS samples the first bit
    // received sits at bit 0 (LSB-first, right-aligned).
    always_comb begin
        state_nxt  = state;
        scnt_nxt   = scnt;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        perr_nxt   = perr_q;
        deliver    = 1'b0;
        ferr_now   = 1'b0;

        if (tick_16) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nxt = START;
                        scnt_nxt  = 4'd0;
                    end
                end

                START: begin
                    // Mid start bit: a high line here was only a glitch.
                    if (scnt == 4'd7) begin
                        scnt_nxt = 4'd0;
                        if (!rx_s) begin
                            state_nxt  = DATA;
                            bitcnt_nxt = 3'd0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        scnt_nxt = scnt + 4'd1;
                    end
                end

                DATA: begin
                    if (scnt == 4'd15) begin
                        shreg_nxt  = {rx_s, shreg[DATA_BITS-1:1]};
                        scnt_nxt   = 4'd0;
                        bitcnt_nxt = bitcnt + 3'd1;
                        if (bitcnt == LAST_BIT) begin
                            perr_nxt  = 1'b0;
                            state_nxt = PAR_EN_BIT ? PARITY : STOP;
                        end
                    end else begin
                        scnt_nxt = scnt + 4'd1;
                    end
                end

                PARITY: begin
                    if (scnt == 4'd15) begin
                        perr_nxt  = (^shreg) ^ rx_s ^ PAR_ODD_BIT;
                        scnt_nxt  = 4'd0;
                        state_nxt = STOP;
                    end else begin
                        scnt_nxt = scnt + 4'd1;
                    end
                end

                STOP: begin
                    // A low line here (break) lets IDLE restart on the very
                    // next tick; the frame is still delivered with frame_err.
                    if (scnt == 4'd15) begin
                        deliver   = 1'b1;
                        ferr_now  = ~rx_s;
                        scnt_nxt  = 4'd0;
                        state_nxt = IDLE;
                    end else begin
                        scnt_nxt = scnt + 4'd1;
                    end
                end

                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output register and handshake. A delivery on the same clk as a
    // consumption replaces the word, so rx_valid stays high throughout.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg;
                    frame_err  <= ferr_now;
                    parity_err <= PAR_EN_BIT & perr_q;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        busy = (state != IDLE);
    end

endmodule
